// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM state type and op classification helpers
// Purpose: single source of truth for the ALU operation encoding used by the
//          execution unit, its shift step and any consumer of the unit.
// Contents: OP_* codes, state_t {IDLE, SHIFT, DONE}, is_shift_op(), is_legal_op().

package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LS  = 4'b0011;
    localparam logic [3:0] OP_SRS = 4'b0100;
    localparam logic [3:0] OP_URS = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_ROR = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_LS) || (op == OP_URS) || (op == OP_SRS) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || is_shift_op(op);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - request/response bundle of the execution-stage ALU
// Purpose: groups the request handshake (in_valid/in_ready, op, a, b) and the
//          response handshake (out_valid/out_ready, result and flags).
// Modports: master = issuing stage (register-file read / writeback side),
//           slave  = the ALU execution unit.

interface alu_exec_unit_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, illegal
    );
endinterface

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational single-bit shift/rotate step
// Purpose: applies one 1-bit step of LS/URS/SRS/ROR/ROL to a value.
// Ports: op (in, 4)       operation code
//        value (in, W)    current working value
//        next_value (out, W) value after one step
//        bit_out (out, 1) bit that left the word on this step
// Non-shift codes pass the value through with bit_out = 0.

module alu_shift_step
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] value,
    output logic [W-1:0] next_value,
    output logic         bit_out
);

    always_comb begin
        next_value = value;
        bit_out    = 1'b0;
        case (op)
            OP_LS: begin
                next_value = {value[W-2:0], 1'b0};
                bit_out    = value[W-1];
            end
            OP_URS: begin
                next_value = {1'b0, value[W-1:1]};
                bit_out    = value[0];
            end
            OP_SRS: begin
                next_value = {value[W-1], value[W-1:1]};
                bit_out    = value[0];
            end
            OP_ROR: begin
                next_value = {value[0], value[W-1:1]};
                bit_out    = value[0];
            end
            OP_ROL: begin
                next_value = {value[W-2:0], value[W-1]};
                bit_out    = value[W-1];
            end
            default: begin
                next_value = value;
                bit_out    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execution-stage ALU with valid/ready request and response
// Purpose: computes logic/arithmetic ops in one cycle and shifts/rotates one bit
//          per cycle, presenting a registered result plus zero/carry/ovf/illegal.
// Ports: clk (in)  rising-edge clock
//        rst (in)  synchronous active-high reset
//        bus (alu_exec_unit_if.slave) request: in_valid/in_ready, op, a, b;
//            response: out_valid/out_ready, result, zero, carry, ovf, illegal.
// Parameters: W operand width (power of 2, >= 4); SW = $clog2(W) is derived.

module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_unit_if.slave   bus
);

    localparam int SW = $clog2(W);

    state_t         state_q, state_d;

    // result_q doubles as the shift working register; it is only presented as
    // a valid result once the FSM reaches DONE.
    logic [W-1:0]   result_q;
    logic           zero_q, carry_q, ovf_q, illegal_q;
    logic [3:0]     op_q;
    logic [SW-1:0]  cnt_q;

    logic           accept;
    logic [SW-1:0]  amt;
    logic           start_shift;

    logic [W:0]     sum_w, diff_w;
    logic [W-1:0]   imm_res;
    logic           imm_c, imm_v, imm_i;

    logic [W-1:0]   step_value;
    logic           step_bit;

    assign accept      = bus.in_valid && (state_q == IDLE);
    assign amt         = bus.b[SW-1:0];
    assign start_shift = is_shift_op(bus.op) && (amt != '0);

    // Single-cycle datapath; shift ops only land here when the amount is 0,
    // in which case the operand passes through unchanged.
    always_comb begin
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
        diff_w  = {1'b0, bus.a} - {1'b0, bus.b};
        imm_res = '0;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        imm_i   = 1'b0;
        case (bus.op)
            OP_AND: imm_res = bus.a & bus.b;
            OP_OR:  imm_res = bus.a | bus.b;
            OP_ADD: begin
                imm_res = sum_w[W-1:0];
                imm_c   = sum_w[W];
                imm_v   = (bus.a[W-1] == bus.b[W-1]) && (sum_w[W-1] != bus.a[W-1]);
            end
            OP_SUB: begin
                imm_res = diff_w[W-1:0];
                // The extra top bit of the widened difference is the borrow.
                imm_c   = diff_w[W];
                imm_v   = (bus.a[W-1] != bus.b[W-1]) && (diff_w[W-1] != bus.a[W-1]);
            end
            OP_SLT: imm_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_LS, OP_URS, OP_SRS, OP_ROR, OP_ROL: imm_res = bus.a;
            default: imm_i = 1'b1;
        endcase
    end

    alu_shift_step #(
        .W (W)
    ) u_shift_step (
        .op         (op_q),
        .value      (result_q),
        .next_value (step_value),
        .bit_out    (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = start_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // cnt_q is never 0 here: SHIFT is only entered with amount > 0.
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            op_q      <= OP_AND;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.op;
                        if (start_shift) begin
                            result_q  <= bus.a;
                            cnt_q     <= amt;
                            zero_q    <= 1'b0;
                            carry_q   <= 1'b0;
                            ovf_q     <= 1'b0;
                            illegal_q <= 1'b0;
                        end else begin
                            result_q  <= imm_res;
                            zero_q    <= (imm_res == '0);
                            carry_q   <= imm_c;
                            ovf_q     <= imm_v;
                            illegal_q <= imm_i;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= step_value;
                    carry_q  <= step_bit;
                    cnt_q    <= cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        zero_q <= (step_value == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;

endmodule
